stream_demux1to5: RTL and testbench

- Registered 1-to-5 stream demultiplexer with valid/ready handshakes. It is the distribution counterpart of the 5:1 select mux.
- Routes each input beat (e.g. layer partial sums) to one of five consumers (PE lanes / buffers), selected per beat by select_i.
- Each destination has a one-entry output register, so consumers back-pressure independently.
- Illegal selects are dropped, counted and flagged.

---
 rtl/mlp_stream_pkg.sv | 20 ++
 rtl/stream_slot.sv | 46 ++++
 rtl/stream_demux1to5.sv | 108 ++++++++++
 tb/tb_stream_demux1to5.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_stream_pkg.sv
// Shared constants and helpers for the stream distribution blocks.
// Lane numbering and select legality live here so every user agrees.
package mlp_stream_pkg;

    localparam int NumLanes = 5;
    localparam int SelWidth = 3;

    typedef logic [SelWidth-1:0] sel_t;

    localparam sel_t LANE0 = 3'd0;
    localparam sel_t LANE1 = 3'd1;
    localparam sel_t LANE2 = 3'd2;
    localparam sel_t LANE3 = 3'd3;
    localparam sel_t LANE4 = 3'd4;

    function automatic logic sel_legal(input sel_t sel);
        return int'(sel) < NumLanes;
    endfunction

endpackage

// File: rtl/stream_slot.sv
// One-entry valid/ready output register.
// Load has priority over drain, so a drain and a refill in one cycle cost no bubble.
module stream_slot #(
    parameter int DWidth = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DWidth-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DWidth-1:0] data_o,
    output logic              full_o
);

    logic              r_valid;
    logic [DWidth-1:0] r_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (load_i) begin
            r_valid <= 1'b1;
            r_data  <= data_i;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign full_o  = r_valid;

    // A held beat must not move until the consumer takes it.
    a_hold_stable : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (r_valid && !ready_i) |=> (r_valid && $stable(r_data))
    );

    a_load_room : assert property (
        @(posedge clk_i) disable iff (rst_i)
        load_i |-> (!r_valid || ready_i)
    );

endmodule

// File: rtl/stream_demux1to5.sv
// Registered 1-to-5 stream demultiplexer with per-lane output slots.
// Illegal selects are consumed, dropped, counted and flagged.
module stream_demux1to5
    import mlp_stream_pkg::*;
#(
    parameter int DWidth   = 32,
    parameter int CntWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [DWidth-1:0]   data_i,
    input  logic [2:0]          select_i,
    output logic [DWidth-1:0]   data0_o,
    output logic [DWidth-1:0]   data1_o,
    output logic [DWidth-1:0]   data2_o,
    output logic [DWidth-1:0]   data3_o,
    output logic [DWidth-1:0]   data4_o,
    output logic [4:0]          valid_o,
    input  logic [4:0]          ready_i,
    output logic                err_o,
    output logic [CntWidth-1:0] drop_cnt_o,
    input  logic                clear_i
);

    localparam logic [CntWidth-1:0] CntMax = '1;

    logic              w_legal;
    logic              w_ready;
    logic              w_accept;
    logic              w_drop;
    logic [4:0]        w_load;
    logic [4:0]        w_full;
    logic [DWidth-1:0] w_data [NumLanes];

    logic                r_err;
    logic [CntWidth-1:0] r_cnt;

    assign w_legal = sel_legal(select_i);

    // Only the addressed lane matters; illegal beats are always taken.
    always_comb begin
        w_ready = 1'b1;
        case (select_i)
            LANE0:   w_ready = !w_full[0] || ready_i[0];
            LANE1:   w_ready = !w_full[1] || ready_i[1];
            LANE2:   w_ready = !w_full[2] || ready_i[2];
            LANE3:   w_ready = !w_full[3] || ready_i[3];
            LANE4:   w_ready = !w_full[4] || ready_i[4];
            default: w_ready = 1'b1;
        endcase
    end

    assign ready_o  = w_ready;
    assign w_accept = valid_i && w_ready;
    assign w_drop   = w_accept && !w_legal;

    for (genvar k = 0; k < NumLanes; k++) begin : g_lane
        assign w_load[k] = w_accept && w_legal
                        && (select_i == SelWidth'(k));

        stream_slot #(
            .DWidth (DWidth)
        ) u_slot (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .load_i  (w_load[k]),
            .data_i  (data_i),
            .ready_i (ready_i[k]),
            .valid_o (valid_o[k]),
            .data_o  (w_data[k]),
            .full_o  (w_full[k])
        );
    end

    assign data0_o = w_data[0];
    assign data1_o = w_data[1];
    assign data2_o = w_data[2];
    assign data3_o = w_data[3];
    assign data4_o = w_data[4];

    // Clear resets first, then a same-cycle drop is still recorded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
            r_cnt <= '0;
        end else if (clear_i) begin
            r_err <= w_drop;
            r_cnt <= w_drop ? CntWidth'(1) : '0;
        end else if (w_drop) begin
            r_err <= 1'b1;
            if (r_cnt != CntMax) begin
                r_cnt <= r_cnt + CntWidth'(1);
            end
        end
    end

    assign err_o      = r_err;
    assign drop_cnt_o = r_cnt;

    a_in_hold : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (valid_i && !w_ready) |=>
            (valid_i && $stable(data_i) && $stable(select_i))
    );

endmodule

// File: tb/tb_stream_demux1to5.sv
// Directed bench for stream_demux1to5.
// A second instance with a 2-bit counter covers saturation.
module tb_stream_demux1to5;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_i;
    logic [2:0]  select_i;
    logic [31:0] d0, d1, d2, d3, d4;
    logic [4:0]  valid_o;
    logic [4:0]  ready_i;
    logic        err_o;
    logic [7:0]  cnt;
    logic        clear;

    logic        v2;
    logic        rdy2;
    logic [2:0]  sel2;
    logic [31:0] q2 [5];
    logic [4:0]  vo2;
    logic        err2;
    logic [1:0]  cnt2;

    int total;
    int bad;

    stream_demux1to5 #(.DWidth(32), .CntWidth(8)) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .select_i   (select_i),
        .data0_o    (d0),
        .data1_o    (d1),
        .data2_o    (d2),
        .data3_o    (d3),
        .data4_o    (d4),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .err_o      (err_o),
        .drop_cnt_o (cnt),
        .clear_i    (clear)
    );

    stream_demux1to5 #(.DWidth(32), .CntWidth(2)) u_dut2 (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (v2),
        .ready_o    (rdy2),
        .data_i     (32'h5A5A_0000),
        .select_i   (sel2),
        .data0_o    (q2[0]),
        .data1_o    (q2[1]),
        .data2_o    (q2[2]),
        .data3_o    (q2[3]),
        .data4_o    (q2[4]),
        .valid_o    (vo2),
        .ready_i    (5'b11111),
        .err_o      (err2),
        .drop_cnt_o (cnt2),
        .clear_i    (1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        total++;
        if (valid_o !== 5'b0 || err_o !== 1'b0 || cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_state got v=%b e=%b c=%0d exp 0/0/0",
                     valid_o, err_o, cnt);
        end
        ready_i = 5'b00000;
        @(negedge clk);
        valid_i = 1'b1; select_i = 3'd0; data_i = 32'hAAAA_0000;
        @(negedge clk);
        select_i = 3'd3; data_i = 32'hBBBB_3333;
        @(negedge clk);
        valid_i = 1'b0;
        total++;
        if (valid_o !== 5'b01001) begin
            bad++;
            $display("FAIL reset_prefill got=%b exp=%b", valid_o, 5'b01001);
        end
        rst = 1'b1;
        #1;
        total++;
        if (valid_o !== 5'b0 || d0 !== 32'd0 || d3 !== 32'd0
            || err_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_async got v=%b d0=%h d3=%h e=%b exp 0",
                     valid_o, d0, d3, err_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (valid_o !== 5'b0) begin
            bad++;
            $display("FAIL reset_after got=%b exp=0", valid_o);
        end
    endtask

    task automatic test_single();
        ready_i = 5'b11111;
        @(negedge clk);
        valid_i = 1'b1; select_i = 3'd2; data_i = 32'hDEAD_BEEF;
        #1;
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL single_ready got=%b exp=1", ready_o);
        end
        @(negedge clk);
        valid_i = 1'b0;
        total++;
        if (valid_o !== 5'b00100 || d2 !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL single_out got v=%b d=%h exp 00100/deadbeef",
                     valid_o, d2);
        end
        @(negedge clk);
        total++;
        if (valid_o !== 5'b0 || d2 !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL single_drain got v=%b d=%h exp 0/deadbeef",
                     valid_o, d2);
        end
    endtask

    task automatic test_backpressure();
        ready_i = 5'b11101;
        @(negedge clk);
        valid_i = 1'b1; select_i = 3'd1; data_i = 32'h1;
        #1;
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_first_ready got=%b exp=1", ready_o);
        end
        @(negedge clk);
        select_i = 3'd4; data_i = 32'h44;
        #1;
        total++;
        if (ready_o !== 1'b1 || valid_o !== 5'b00010 || d1 !== 32'h1) begin
            bad++;
            $display("FAIL bp_lane4 got r=%b v=%b d1=%h exp 1/00010/1",
                     ready_o, valid_o, d1);
        end
        @(negedge clk);
        total++;
        if (valid_o !== 5'b10010 || d4 !== 32'h44) begin
            bad++;
            $display("FAIL bp_lane4_out got v=%b d4=%h exp 10010/44",
                     valid_o, d4);
        end
        select_i = 3'd1; data_i = 32'h2;
        #1;
        total++;
        if (ready_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_stall_ready got=%b exp=0", ready_o);
        end
        @(negedge clk);
        total++;
        if (ready_o !== 1'b0 || valid_o !== 5'b00010 || d1 !== 32'h1) begin
            bad++;
            $display("FAIL bp_hold got r=%b v=%b d1=%h exp 0/00010/1",
                     ready_o, valid_o, d1);
        end
        ready_i = 5'b11111;
        #1;
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready got=%b exp=1", ready_o);
        end
        @(negedge clk);
        valid_i = 1'b0;
        total++;
        if (valid_o !== 5'b00010 || d1 !== 32'h2) begin
            bad++;
            $display("FAIL bp_second got v=%b d1=%h exp 00010/2",
                     valid_o, d1);
        end
        @(negedge clk);
        total++;
        if (valid_o !== 5'b0) begin
            bad++;
            $display("FAIL bp_empty got=%b exp=0", valid_o);
        end
    endtask

    task automatic test_back_to_back();
        ready_i = 5'b11111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                total++;
                if (valid_o[0] !== 1'b1 || d0 !== 32'(i - 1)) begin
                    bad++;
                    $display("FAIL stream_out[%0d] got v=%b d=%0d exp 1/%0d",
                             i, valid_o[0], d0, i - 1);
                end
            end
            valid_i = 1'b1; select_i = 3'd0; data_i = 32'(i);
            #1;
            total++;
            if (ready_o !== 1'b1) begin
                bad++;
                $display("FAIL stream_ready[%0d] got=%b exp=1", i, ready_o);
            end
        end
        @(negedge clk);
        valid_i = 1'b0;
        total++;
        if (valid_o[0] !== 1'b1 || d0 !== 32'd7) begin
            bad++;
            $display("FAIL stream_last got v=%b d=%0d exp 1/7",
                     valid_o[0], d0);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        ready_i = 5'b00000;
        for (int s = 5; s < 8; s++) begin
            @(negedge clk);
            valid_i = 1'b1; select_i = 3'(s); data_i = 32'hBAD0 + 32'(s);
            #1;
            total++;
            if (ready_o !== 1'b1) begin
                bad++;
                $display("FAIL ill_ready[%0d] got=%b exp=1", s, ready_o);
            end
        end
        @(negedge clk);
        valid_i = 1'b0;
        total++;
        if (valid_o !== 5'b0 || err_o !== 1'b1 || cnt !== 8'd3) begin
            bad++;
            $display("FAIL ill_count got v=%b e=%b c=%0d exp 0/1/3",
                     valid_o, err_o, cnt);
        end
        valid_i = 1'b1; select_i = 3'd5; clear = 1'b1;
        @(negedge clk);
        valid_i = 1'b0; clear = 1'b0;
        total++;
        if (err_o !== 1'b1 || cnt !== 8'd1) begin
            bad++;
            $display("FAIL ill_clear_drop got e=%b c=%0d exp 1/1", err_o, cnt);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        total++;
        if (err_o !== 1'b0 || cnt !== 8'd0) begin
            bad++;
            $display("FAIL ill_clear got e=%b c=%0d exp 0/0", err_o, cnt);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            v2 = 1'b1; sel2 = 3'd6;
            if (i == 3) begin
                total++;
                if (cnt2 !== 2'd3 || rdy2 !== 1'b1) begin
                    bad++;
                    $display("FAIL sat_three got c=%0d r=%b exp 3/1",
                             cnt2, rdy2);
                end
            end
        end
        @(negedge clk);
        v2 = 1'b0;
        total++;
        if (cnt2 !== 2'd3 || err2 !== 1'b1 || vo2 !== 5'b0) begin
            bad++;
            $display("FAIL sat_six got c=%0d e=%b v=%b exp 3/1/0",
                     cnt2, err2, vo2);
        end
    endtask

    task automatic fill_lanes(input logic [4:0] mask);
        for (int k = 0; k < 5; k++) begin
            if (mask[k]) begin
                @(negedge clk);
                valid_i = 1'b1; select_i = 3'(k); data_i = 32'(10 + k);
            end
        end
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic test_parallel_drain();
        ready_i = 5'b00000;
        fill_lanes(5'b11111);
        total++;
        if (valid_o !== 5'b11111) begin
            bad++;
            $display("FAIL par_full got=%b exp=11111", valid_o);
        end
        ready_i = 5'b10101;
        @(negedge clk);
        ready_i = 5'b00000;
        total++;
        if (valid_o !== 5'b01010 || d1 !== 32'd11 || d3 !== 32'd13) begin
            bad++;
            $display("FAIL par_drain got v=%b d1=%0d d3=%0d exp 01010/11/13",
                     valid_o, d1, d3);
        end
        fill_lanes(5'b10101);
        total++;
        if (valid_o !== 5'b11111) begin
            bad++;
            $display("FAIL par_refull got=%b exp=11111", valid_o);
        end
        ready_i = 5'b10101;
        valid_i = 1'b1; select_i = 3'd2; data_i = 32'd99;
        #1;
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL par_reload_ready got=%b exp=1", ready_o);
        end
        @(negedge clk);
        valid_i = 1'b0; ready_i = 5'b00000;
        total++;
        if (valid_o !== 5'b01110 || d2 !== 32'd99 || d4 !== 32'd14) begin
            bad++;
            $display("FAIL par_reload got v=%b d2=%0d d4=%0d exp 01110/99/14",
                     valid_o, d2, d4);
        end
        ready_i = 5'b11111;
        @(negedge clk);
        total++;
        if (valid_o !== 5'b0) begin
            bad++;
            $display("FAIL par_final got=%b exp=0", valid_o);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        valid_i  = 1'b0;
        data_i   = '0;
        select_i = '0;
        ready_i  = '0;
        clear    = 1'b0;
        v2       = 1'b0;
        sel2     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        test_parallel_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
